// File: rtl/qspi_xfer_counter_pkg.sv
// Shared types and step decode for the QSPI transfer bit counter.
// Optional feature macro used elsewhere in this slice: QSPI_CNT_ALMOST_EN.
package qspi_cnt_pkg;

  typedef enum logic [1:0] {
    LANE_X1   = 2'd0,
    LANE_X2   = 2'd1,
    LANE_X4   = 2'd2,
    LANE_RSVD = 2'd3
  } lane_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cnt_state_e;

  // Bits advanced per SCK tick. The reserved encoding behaves as x1; any
  // lane wider than the build supports is clamped to the widest one.
  function automatic logic [4:0] lane_step(input lane_mode_e lane,
                                           input int unsigned max_log2);
    int unsigned lg;
    if (lane == LANE_RSVD) begin
      lg = 0;
    end else begin
      lg = {30'd0, lane};
    end
    if (lg > max_log2) begin
      lg = max_log2;
    end
    return 5'(32'd1 << lg);
  endfunction

endpackage

// File: rtl/qspi_xfer_counter_if.sv
// Control/status bundle between the QSPI phase FSM (master) and the
// transfer bit counter (slave).
// Optional feature macro: QSPI_CNT_ALMOST_EN adds almost_thresh/almost_done.
interface qspi_xfer_counter_if #(
  parameter int CNT_W = 8
);

  logic             start;
  logic             stop;
  logic             tick;
  logic             mode_reload;
  logic [1:0]       lane_mode;
  logic [CNT_W-1:0] target;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;
  logic             start_err;
  logic             aborted;
`ifdef QSPI_CNT_ALMOST_EN
  logic [CNT_W-1:0] almost_thresh;
  logic             almost_done;
`endif

  modport master (
    output start, stop, tick, mode_reload, lane_mode, target,
`ifdef QSPI_CNT_ALMOST_EN
    output almost_thresh,
    input  almost_done,
`endif
    input  busy, done, remaining, start_err, aborted
  );

  modport slave (
    input  start, stop, tick, mode_reload, lane_mode, target,
`ifdef QSPI_CNT_ALMOST_EN
    input  almost_thresh,
    output almost_done,
`endif
    output busy, done, remaining, start_err, aborted
  );

endinterface

// File: rtl/qspi_xfer_counter.sv
// Bit counter for QSPI address/dummy/mode/data phases. Counts down the
// latched target by 1, 2 or 4 bits per enabled tick, with one-shot or
// auto-reload completion, abort, and error/abort status pulses.
// Optional feature macro: QSPI_CNT_ALMOST_EN (almost_done prefetch hint).
module qspi_xfer_counter
  import qspi_cnt_pkg::*;
#(
  parameter int          CNT_W         = 8,
  parameter int unsigned MAX_LANE_LOG2 = 2
) (
  input logic                 clk,
  input logic                 rst,
  qspi_xfer_counter_if.slave  cnt_if
);

  cnt_state_e       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] target_q, target_d;
  lane_mode_e       lane_q, lane_d;
  logic             reload_q, reload_d;
  logic             done_q, done_d;
  logic             start_err_q, start_err_d;
  logic             aborted_q, aborted_d;
  logic [CNT_W-1:0] step;
`ifdef QSPI_CNT_ALMOST_EN
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic             almost_q, almost_d;
  logic             reload_evt;
`endif

  assign step = CNT_W'(lane_step(lane_q, MAX_LANE_LOG2));

  // Next-state decode: start/stop/tick handling and completion detection.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    target_d    = target_q;
    lane_d      = lane_q;
    reload_d    = reload_q;
    done_d      = 1'b0;
    start_err_d = 1'b0;
    aborted_d   = 1'b0;
`ifdef QSPI_CNT_ALMOST_EN
    thresh_d    = thresh_q;
    reload_evt  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // stop is meaningless here, so a same-cycle stop is simply ignored
        if (cnt_if.start) begin
          target_d    = cnt_if.target;
          lane_d      = lane_mode_e'(cnt_if.lane_mode);
          reload_d    = cnt_if.mode_reload;
          remaining_d = cnt_if.target;
`ifdef QSPI_CNT_ALMOST_EN
          thresh_d    = cnt_if.almost_thresh;
`endif
          if (cnt_if.target != '0) begin
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        start_err_d = cnt_if.start;
        if (cnt_if.stop) begin
          // abort beats a completion landing on the same tick
          state_d     = IDLE;
          remaining_d = '0;
          aborted_d   = 1'b1;
        end else if (cnt_if.tick) begin
          if (remaining_q <= step) begin
            // final (possibly partial) step saturates instead of wrapping
            done_d = 1'b1;
            if (reload_q) begin
              remaining_d = target_q;
`ifdef QSPI_CNT_ALMOST_EN
              reload_evt  = 1'b1;
`endif
            end else begin
              remaining_d = '0;
              state_d     = IDLE;
            end
          end else begin
            remaining_d = remaining_q - step;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
`ifdef QSPI_CNT_ALMOST_EN
    // level is dropped for the reload cycle so each pass re-arms cleanly
    almost_d = (state_d == RUN) && (remaining_d != '0) &&
               (remaining_d <= thresh_d) && !reload_evt;
`endif
  end

  // State, latched configuration and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      target_q    <= '0;
      lane_q      <= LANE_X1;
      reload_q    <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      aborted_q   <= 1'b0;
`ifdef QSPI_CNT_ALMOST_EN
      thresh_q    <= '0;
      almost_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      target_q    <= target_d;
      lane_q      <= lane_d;
      reload_q    <= reload_d;
      done_q      <= done_d;
      start_err_q <= start_err_d;
      aborted_q   <= aborted_d;
`ifdef QSPI_CNT_ALMOST_EN
      thresh_q    <= thresh_d;
      almost_q    <= almost_d;
`endif
    end
  end

  assign cnt_if.busy      = (state_q == RUN);
  assign cnt_if.done      = done_q;
  assign cnt_if.remaining = remaining_q;
  assign cnt_if.start_err = start_err_q;
  assign cnt_if.aborted   = aborted_q;
`ifdef QSPI_CNT_ALMOST_EN
  assign cnt_if.almost_done = almost_q;
`endif

endmodule

// File: tb/tb_qspi_xfer_counter.sv
// Self-checking bench for qspi_xfer_counter: a vector table plus hand-built
// multi-cycle sequences, checked through an expected-result queue.
// Define QSPI_CNT_ALMOST_EN to also exercise almost_done.
module tb_qspi_xfer_counter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  qspi_xfer_counter_if #(.CNT_W(8)) bus();

  qspi_xfer_counter #(.CNT_W(8), .MAX_LANE_LOG2(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .cnt_if (bus.slave)
  );

  typedef struct {
    logic       rs, st, sp, tk, rl;
    logic [1:0] ln;
    logic [7:0] tg;
    logic       b, d;
    logic [7:0] r;
    logic       se, ab;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input int rs, st, sp, tk, rl, ln, tg,
                              input int b, d, r, se, ab);
    vec_t v;
    v.rs = rs[0]; v.st = st[0]; v.sp = sp[0]; v.tk = tk[0]; v.rl = rl[0];
    v.ln = ln[1:0]; v.tg = tg[7:0];
    v.b = b[0]; v.d = d[0]; v.r = r[7:0]; v.se = se[0]; v.ab = ab[0];
    return v;
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    rst             = v.rs;
    bus.start       = v.st;
    bus.stop        = v.sp;
    bus.tick        = v.tk;
    bus.mode_reload = v.rl;
    bus.lane_mode   = v.ln;
    bus.target      = v.tg;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.busy !== e.b || bus.done !== e.d || bus.remaining !== e.r ||
        bus.start_err !== e.se || bus.aborted !== e.ab) begin
      n_errors++;
      $display("FAIL %s: got busy=%0b done=%0b rem=%0d serr=%0b abort=%0b, want busy=%0b done=%0b rem=%0d serr=%0b abort=%0b",
               tag, bus.busy, bus.done, bus.remaining, bus.start_err, bus.aborted,
               e.b, e.d, e.r, e.se, e.ab);
    end else begin
      $display("ok   %s: busy=%0b done=%0b rem=%0d serr=%0b abort=%0b",
               tag, bus.busy, bus.done, bus.remaining, bus.start_err, bus.aborted);
    end
  endtask

  logic [7:0] rr [6];

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.tick = 1'b0;
    bus.mode_reload = 1'b0; bus.lane_mode = 2'd0; bus.target = 8'd0;
`ifdef QSPI_CNT_ALMOST_EN
    bus.almost_thresh = 8'd0;
`endif

    // reset state
    tbl.push_back(mk(1,0,0,0,0,0,0,   0,0,0,0,0));
    tbl.push_back(mk(1,1,0,1,1,2,9,   0,0,0,0,0));
    // x1 one-shot, target 8
    tbl.push_back(mk(0,1,0,0,0,0,8,   1,0,8,0,0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0,0,0,1,0,0,0, (k < 8) ? 1 : 0, (k == 8) ? 1 : 0, 8 - k, 0, 0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   0,0,0,0,0));
    // x4, target 10, partial last step, tick gap holds
    tbl.push_back(mk(0,1,0,0,0,2,10,  1,0,10,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   1,0,6,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,   1,0,6,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   1,0,2,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   0,1,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   0,0,0,0,0));
    // x2, target 5
    tbl.push_back(mk(0,1,0,0,0,1,5,   1,0,5,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   1,0,3,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   1,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   0,1,0,0,0));
    // target 0: done next cycle, never busy
    tbl.push_back(mk(0,1,0,1,0,0,0,   0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,0,0,0));
    // reserved lane counts as x1
    tbl.push_back(mk(0,1,0,0,0,3,3,   1,0,3,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   1,0,2,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   1,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   0,1,0,0,0));
    // start during RUN, then start+stop in RUN
    tbl.push_back(mk(0,1,0,0,0,0,5,   1,0,5,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   1,0,4,0,0));
    tbl.push_back(mk(0,1,0,1,1,2,9,   1,0,3,1,0));
    tbl.push_back(mk(0,0,0,0,1,2,9,   1,0,3,0,0));
    tbl.push_back(mk(0,0,0,1,1,2,9,   1,0,2,0,0));
    tbl.push_back(mk(0,1,1,1,0,0,7,   0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,0,0,0));
    // stop on the completing tick
    tbl.push_back(mk(0,1,0,0,0,0,2,   1,0,2,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   1,0,1,0,0));
    tbl.push_back(mk(0,0,1,1,0,0,0,   0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,0,0,0));
    // stop in IDLE, start+stop in IDLE, then real abort
    tbl.push_back(mk(0,0,1,0,0,0,0,   0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,4,   1,0,4,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,0,   0,0,0,0,1));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // auto-reload, target 3, tick every other cycle
    rr = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd3, 8'd3};
    apply(mk(0,1,0,0,1,0,3, 1,0,3,0,0), "rl_start");
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 6; c++)
        apply(mk(0,0,0,(c % 2 == 0) ? 1 : 0,0,0,0, 1,(c == 4) ? 1 : 0,rr[c],0,0),
              $sformatf("rl_p%0d_c%0d", p, c));
    apply(mk(0,0,1,0,0,0,0, 0,0,0,0,1), "rl_stop");
    apply(mk(0,0,0,1,0,0,0, 0,0,0,0,0), "rl_after");

    // maximum target with x1
    apply(mk(0,1,0,0,0,0,255, 1,0,255,0,0), "max_start");
    for (int k = 1; k <= 255; k++)
      apply(mk(0,0,0,1,0,0,0, (k < 255) ? 1 : 0,(k == 255) ? 1 : 0,255 - k,0,0),
            $sformatf("max_t%0d", k));

    // reset mid-count
    apply(mk(0,1,0,0,0,0,20, 1,0,20,0,0), "rst_start");
    for (int k = 1; k <= 3; k++)
      apply(mk(0,0,0,1,0,0,0, 1,0,20 - k,0,0), $sformatf("rst_t%0d", k));
    apply(mk(1,0,1,1,0,0,0, 0,0,0,0,0), "rst_hit");
    apply(mk(0,0,0,1,0,0,0, 0,0,0,0,0), "rst_after");

`ifdef QSPI_CNT_ALMOST_EN
    // almost_done: target 16, threshold 4, x2
    bus.almost_thresh = 8'd4;
    apply(mk(0,1,0,0,0,1,16, 1,0,16,0,0), "alm_start");
    bus.almost_thresh = 8'd200;
    n_checks++;
    if (bus.almost_done !== 1'b0) begin
      n_errors++;
      $display("FAIL alm_start_level: got almost=%0b want 0", bus.almost_done);
    end
    for (int k = 1; k <= 8; k++) begin
      logic want;
      want = (k == 6 || k == 7);
      apply(mk(0,0,0,1,0,0,0, (k < 8) ? 1 : 0,(k == 8) ? 1 : 0,16 - 2 * k,0,0),
            $sformatf("alm_t%0d", k));
      n_checks++;
      if (bus.almost_done !== want) begin
        n_errors++;
        $display("FAIL alm_level_t%0d: got almost=%0b want %0b", k, bus.almost_done, want);
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
